// File: rtl/vram_wb_pkg.sv
// Shared types and constants for the text-mode VRAM CPU write buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package vram_wb_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    // Character pixel counter value on which an active-display write may
    // start; the transaction then owns the bus for phases 4, 5 and 6.
    localparam logic [3:0] STEAL_PHASE = 4'd3;

    typedef enum logic {
        CHAR = 1'b0,
        ATTR = 1'b1
    } plane_t;

    typedef struct packed {
        plane_t              plane;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending VRAM write entries.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: push while full is ignored; pop while empty is ignored.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset (empties FIFO)
//   push, push_dat   enqueue request and entry
//   pop              dequeue the head entry
//   head_dat         current head entry (undefined contents when empty)
//   full, empty      occupancy flags, derived from the registered count
//   count            number of stored entries
module wb_fifo
    import vram_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wb_entry_t              push_dat,
    input  logic                   pop,
    output wb_entry_t              head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Full is decided on the registered count, so a push in a cycle that
    // also pops from a full FIFO is still refused.
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage carries no reset; readers qualify the head with the FSM state.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/vram_write_buffer.sv
// CPU write port for text-mode VRAM: pointer registers, pending-write FIFO, bus-steal FSM.
// Latency: a blanking write strobes 3 cycles after cpu_wr; active display waits for phase 5.
// Backpressure: fifo_full flags no room; a char/attr write while full is dropped and sets overflow.
//
// Ports:
//   clk, reset               pixel clock, synchronous active-high reset
//   cpu_data, cpu_address,   register writes: 0 ptr[7:0], 1 ptr[10:8],
//   cpu_wr                   2 char write, 3 attr write
//   char_phase, display_active, crtc_address   CRTC timing and fetch address
//   vram_address, vram_wdata, vram_wdata_oe,   shared VRAM bus
//   n_we_char, n_we_attr     active-low plane write enables
//   fifo_full, overflow      status
//
// Build option: VRAM_WB_AUTOINC_EN -- pointer advances (with wrap at CELLS)
// after every accepted attribute write.
module vram_write_buffer
    import vram_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CELLS = 2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        cpu_data,
    input  logic [1:0]        cpu_address,
    input  logic              cpu_wr,
    input  logic [3:0]        char_phase,
    input  logic              display_active,
    input  logic [ADDR_W-1:0] crtc_address,
    output logic [ADDR_W-1:0] vram_address,
    output logic [7:0]        vram_wdata,
    output logic              vram_wdata_oe,
    output logic              n_we_char,
    output logic              n_we_attr,
    output logic              fifo_full,
    output logic              overflow
);

`ifdef VRAM_WB_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    wb_state_t          state;
    wb_state_t          state_nxt;
    logic [ADDR_W-1:0]  pointer;
    logic [ADDR_W-1:0]  pointer_inc;
    wb_entry_t          push_dat;
    wb_entry_t          head;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               wr_data_reg;
    logic               push_ok;
    logic               pop;
    logic               bus_owned;

    assign wr_data_reg = cpu_wr && cpu_address[1];
    assign push_ok     = wr_data_reg && !fifo_full;

    assign push_dat.plane = cpu_address[0] ? ATTR : CHAR;
    assign push_dat.addr  = pointer;
    assign push_dat.data  = cpu_data;

    // Out-of-range pointers (written directly) also fold back to cell 0.
    assign pointer_inc = (pointer >= LAST_CELL) ? '0 : pointer + 11'd1;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wr_data_reg),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pointer <= '0;
        end else if (cpu_wr && cpu_address == 2'd0) begin
            pointer[7:0] <= cpu_data;
        end else if (cpu_wr && cpu_address == 2'd1) begin
            pointer[10:8] <= cpu_data[2:0];
        end else if (AUTOINC && push_ok && cpu_address == 2'd3) begin
            pointer <= pointer_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_data_reg && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && (!display_active || char_phase == STEAL_PHASE)) begin
                    state_nxt = SETUP;
                end
            end
            SETUP:  state_nxt = STROBE;
            STROBE: state_nxt = HOLD;
            HOLD: begin
                pop = 1'b1;
                // The head is being popped this cycle, so back-to-back needs
                // a second entry already present; active display always
                // yields the bus until the next steal window.
                if (fifo_count > CNT_W'(1) && !display_active) begin
                    state_nxt = SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode the registered state, so the enables are glitch-free
    // relative to the state register and the head entry is stable while owned.
    assign bus_owned     = (state != IDLE);
    assign vram_address  = bus_owned ? head.addr : crtc_address;
    assign vram_wdata    = bus_owned ? head.data : 8'h00;
    assign vram_wdata_oe = bus_owned;
    assign n_we_char     = !(state == STROBE && head.plane == CHAR);
    assign n_we_attr     = !(state == STROBE && head.plane == ATTR);

endmodule
